// File: rtl/mini_mips_pkg.sv
// Shared decode constants for the mini MIPS datapath: opcodes, functs, field positions.
// Pure declarations; no latency and no flow control.
package mini_mips_pkg;

   localparam int DATA_W = 32;
   localparam int REG_AW = 3;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int RS_MSB  = 11;
   localparam int RS_LSB  = 9;
   localparam int RT_MSB  = 8;
   localparam int RT_LSB  = 6;
   localparam int RD_MSB  = 5;
   localparam int RD_LSB  = 3;
   localparam int FN_MSB  = 2;
   localparam int FN_LSB  = 0;
   localparam int IMM_MSB = 5;
   localparam int IMM_LSB = 0;

   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_ADDI  = 4'b0001;
   localparam logic [3:0] OP_ANDI  = 4'b0010;
   localparam logic [3:0] OP_ORI   = 4'b0011;
   localparam logic [3:0] OP_NORI  = 4'b0100;
   localparam logic [3:0] OP_SLTI  = 4'b0111;
   localparam logic [3:0] OP_LW    = 4'b1000;
   localparam logic [3:0] OP_SW    = 4'b1001;

   localparam logic [2:0] FN_AND = 3'b000;
   localparam logic [2:0] FN_ADD = 3'b001;
   localparam logic [2:0] FN_SUB = 3'b010;
   localparam logic [2:0] FN_XOR = 3'b011;
   localparam logic [2:0] FN_NOR = 3'b100;
   localparam logic [2:0] FN_OR  = 3'b101;
   localparam logic [2:0] FN_SLT = 3'b110;
   localparam logic [2:0] FN_SLL = 3'b111;

   function automatic logic [DATA_W-1:0] sext6(input logic [5:0] imm);
      return {{(DATA_W-6){imm[5]}}, imm};
   endfunction

endpackage

// File: rtl/mini_mips_dmem.sv
// Word-addressed data memory with combinational read and edge-committed write; contents survive reset.
// Read is zero-cycle, write lands on the next rising edge; no backpressure.
module mini_mips_dmem
   import mini_mips_pkg::*;
#(
   parameter int AW = 5
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_addr,
   input  logic [DATA_W-1:0] i_wr_dat,
   output logic [DATA_W-1:0] o_rd_dat
);

   logic [DATA_W-1:0] memory [0:(1<<AW)-1];

   always_ff @(posedge i_clk) begin
      if (i_we) memory[i_addr] <= i_wr_dat;
   end

   assign o_rd_dat = memory[i_addr];

endmodule

// File: rtl/mini_mips_regfile.sv
// 8 x 32 register file: two combinational read ports, one write port committing on the clock edge.
// $0 hardwired to zero; synchronous reset clears every entry; no backpressure.
module mini_mips_regfile
   import mini_mips_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [REG_AW-1:0] i_ra_addr,
   output logic [DATA_W-1:0] o_ra_dat,
   input  logic [REG_AW-1:0] i_rb_addr,
   output logic [DATA_W-1:0] o_rb_dat,
   input  logic              i_we,
   input  logic [REG_AW-1:0] i_wa_addr,
   input  logic [DATA_W-1:0] i_wa_dat
);

   logic [DATA_W-1:0] registers [0:(1<<REG_AW)-1];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < (1<<REG_AW); i++) registers[i] <= '0;
      end else if (i_we && (i_wa_addr != '0)) begin
         registers[i_wa_addr] <= i_wa_dat;
      end
   end

   // Reads return pre-edge contents, so same-cycle read of the destination sees the old value.
   assign o_ra_dat = (i_ra_addr == '0) ? '0 : registers[i_ra_addr];
   assign o_rb_dat = (i_rb_addr == '0) ? '0 : registers[i_rb_addr];

endmodule

// File: rtl/mini_mips_core.sv
// Single-cycle 16-bit-instruction MIPS-like datapath; result is combinational, state commits next edge, no backpressure.
// Defining MINI_MIPS_TRACE_EN adds a $display line for every committed register or memory write.
module mini_mips_core
   import mini_mips_pkg::*;
#(
   parameter int DMEM_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       instruction,
   output logic [DATA_W-1:0] result
);

   logic [3:0]         w_op;
   logic [REG_AW-1:0]  w_rs;
   logic [REG_AW-1:0]  w_rt;
   logic [REG_AW-1:0]  w_rd;
   logic [2:0]         w_funct;
   logic [5:0]         w_imm6;
   logic [DATA_W-1:0]  w_simm;
   logic [DATA_W-1:0]  w_zimm;
   logic [DATA_W-1:0]  w_rs_dat;
   logic [DATA_W-1:0]  w_rt_dat;
   logic [DATA_W-1:0]  w_rtype;
   logic [DMEM_AW-1:0] w_addr;
   logic [DATA_W-1:0]  w_mem_rd_dat;
   logic               w_reg_we;
   logic [REG_AW-1:0]  w_reg_waddr;
   logic               w_mem_we;

   assign w_op    = instruction[OP_MSB:OP_LSB];
   assign w_rs    = instruction[RS_MSB:RS_LSB];
   assign w_rt    = instruction[RT_MSB:RT_LSB];
   assign w_rd    = instruction[RD_MSB:RD_LSB];
   assign w_funct = instruction[FN_MSB:FN_LSB];
   assign w_imm6  = instruction[IMM_MSB:IMM_LSB];
   assign w_simm  = sext6(w_imm6);
   assign w_zimm  = {{(DATA_W-6){1'b0}}, w_imm6};

   // Adding only the low bits gives the same wrapped word address as the full 32-bit sum.
   assign w_addr = w_rs_dat[DMEM_AW-1:0] + w_simm[DMEM_AW-1:0];

   always_comb begin
      w_rtype = '0;
      case (w_funct)
         FN_AND:  w_rtype = w_rs_dat & w_rt_dat;
         FN_ADD:  w_rtype = w_rs_dat + w_rt_dat;
         FN_SUB:  w_rtype = w_rs_dat - w_rt_dat;
         FN_XOR:  w_rtype = w_rs_dat ^ w_rt_dat;
         FN_NOR:  w_rtype = ~(w_rs_dat | w_rt_dat);
         FN_OR:   w_rtype = w_rs_dat | w_rt_dat;
         FN_SLT:  w_rtype = {{(DATA_W-1){1'b0}}, ($signed(w_rs_dat) < $signed(w_rt_dat))};
         FN_SLL:  w_rtype = w_rs_dat << w_rt_dat[4:0];
         default: w_rtype = '0;
      endcase
   end

   always_comb begin
      result      = '0;
      w_reg_we    = 1'b0;
      w_reg_waddr = w_rt;
      w_mem_we    = 1'b0;
      case (w_op)
         OP_RTYPE: begin
            result      = w_rtype;
            w_reg_we    = 1'b1;
            w_reg_waddr = w_rd;
         end
         OP_ADDI: begin
            result   = w_rs_dat + w_simm;
            w_reg_we = 1'b1;
         end
         OP_ANDI: begin
            result   = w_rs_dat & w_zimm;
            w_reg_we = 1'b1;
         end
         OP_ORI: begin
            result   = w_rs_dat | w_zimm;
            w_reg_we = 1'b1;
         end
         OP_NORI: begin
            result   = ~(w_rs_dat | w_zimm);
            w_reg_we = 1'b1;
         end
         OP_SLTI: begin
            result   = {{(DATA_W-1){1'b0}}, ($signed(w_rs_dat) < $signed(w_simm))};
            w_reg_we = 1'b1;
         end
         OP_LW: begin
            result   = w_mem_rd_dat;
            w_reg_we = 1'b1;
         end
         OP_SW: begin
            result   = {{(DATA_W-DMEM_AW){1'b0}}, w_addr};
            w_mem_we = ~reset;
         end
         default: result = '0;
      endcase
   end

   mini_mips_regfile regs (
      .i_clk     (clk),
      .i_rst     (reset),
      .i_ra_addr (w_rs),
      .o_ra_dat  (w_rs_dat),
      .i_rb_addr (w_rt),
      .o_rb_dat  (w_rt_dat),
      .i_we      (w_reg_we),
      .i_wa_addr (w_reg_waddr),
      .i_wa_dat  (result)
   );

   mini_mips_dmem #(.AW(DMEM_AW)) data_mem (
      .i_clk    (clk),
      .i_we     (w_mem_we),
      .i_addr   (w_addr),
      .i_wr_dat (w_rt_dat),
      .o_rd_dat (w_mem_rd_dat)
   );

`ifdef MINI_MIPS_TRACE_EN
   always @(posedge clk) begin
      if (!reset && w_reg_we && (w_reg_waddr != '0))
         $display("%0t instr=%h reg $%0d <= %h", $time, instruction, w_reg_waddr, result);
      if (w_mem_we)
         $display("%0t instr=%h mem[%0d] <= %h", $time, instruction, w_addr, w_rt_dat);
   end
`endif

endmodule

// File: tb/tb_mini_mips_core.sv
// Directed bench for mini_mips_core: hand-computed results, register and memory contents.
module tb_mini_mips_core;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instruction;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   mini_mips_core #(.DMEM_AW(5)) dut (
      .clk         (clk),
      .reset       (reset),
      .instruction (instruction),
      .result      (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and return at the following falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply(input logic [15:0] ins);
      instruction = ins;
      #1;
   endtask

   function automatic logic [15:0] r_op(input logic [2:0] rs, input logic [2:0] rt,
                                        input logic [2:0] rd, input logic [2:0] fn);
      return {4'b0000, rs, rt, rd, fn};
   endfunction

   function automatic logic [15:0] i_op(input logic [3:0] op, input logic [2:0] rs,
                                        input logic [2:0] rt, input logic [5:0] imm);
      return {op, rs, rt, imm};
   endfunction

   initial begin
      reset       = 1'b1;
      instruction = 16'h0000;
      tick();
      tick();
      for (int k = 0; k < 8; k++) check($sformatf("reset_reg%0d", k), dut.regs.registers[k], 32'd0);
      check("reset_result", result, 32'd0);

      reset = 1'b0;
      // Clear data memory through sw $0, a($0), then load $k = k.
      for (int a = 0; a < 32; a++) begin
         logic [31:0] av;
         av = a;
         apply(i_op(4'b1001, 3'd0, 3'd0, av[5:0]));
         tick();
      end
      for (int k = 1; k < 8; k++) begin
         logic [31:0] kv;
         kv = k;
         apply(i_op(4'b0001, 3'd0, kv[2:0], kv[5:0]));
         check($sformatf("preload_res%0d", k), result, kv);
         tick();
      end

      apply(r_op(3'd2, 3'd4, 3'd1, 3'b001));
      check("add_res", result, 32'd6);
      tick();
      check("add_rd", dut.regs.registers[1], 32'd6);
      for (int k = 2; k < 8; k++) check($sformatf("add_keep%0d", k), dut.regs.registers[k], k);

      apply(r_op(3'd3, 3'd6, 3'd5, 3'b010));
      check("sub_res", result, 32'hFFFF_FFFD);
      tick();
      check("sub_rd", dut.regs.registers[5], 32'hFFFF_FFFD);
      apply(r_op(3'd5, 3'd3, 3'd0, 3'b110));
      check("slt_neg", result, 32'd1);
      apply(r_op(3'd3, 3'd6, 3'd5, 3'b110));
      check("slt_res", result, 32'd1);
      tick();
      check("slt_rd", dut.regs.registers[5], 32'd1);

      apply(i_op(4'b0001, 3'd2, 3'd7, 6'b111111));
      check("addi_res", result, 32'd1);
      tick();
      check("addi_rt", dut.regs.registers[7], 32'd1);
      apply(i_op(4'b0011, 3'd4, 3'd6, 6'b001111));
      check("ori_res", result, 32'd15);
      tick();
      apply(i_op(4'b0100, 3'd1, 3'd1, 6'b000001));
      check("nori_res", result, 32'hFFFF_FFF8);
      tick();
      apply(i_op(4'b0010, 3'd1, 3'd0, 6'b111111));
      check("andi_zext", result, 32'h0000_0038);
      apply(i_op(4'b0111, 3'd1, 3'd1, 6'b000000));
      check("slti_true", result, 32'd1);
      tick();
      check("slti_rt", dut.regs.registers[1], 32'd1);
      apply(i_op(4'b0111, 3'd4, 3'd0, 6'b111111));
      check("slti_false", result, 32'd0);
      apply(i_op(4'b0011, 3'd0, 3'd0, 6'b100000));
      check("ori_zext", result, 32'h0000_0020);

      apply(r_op(3'd6, 3'd4, 3'd0, 3'b000));
      check("and_res", result, 32'd4);
      apply(r_op(3'd6, 3'd4, 3'd0, 3'b011));
      check("xor_res", result, 32'd11);
      apply(r_op(3'd2, 3'd4, 3'd0, 3'b100));
      check("nor_res", result, 32'hFFFF_FFF9);
      apply(r_op(3'd2, 3'd4, 3'd0, 3'b101));
      check("or_res", result, 32'd6);
      apply(r_op(3'd6, 3'd3, 3'd0, 3'b111));
      check("sll_res", result, 32'd120);

      apply(i_op(4'b1001, 3'd0, 3'd3, 6'd0));
      check("sw0_res", result, 32'd0);
      tick();
      check("sw0_mem", dut.data_mem.memory[0], 32'd3);
      apply(i_op(4'b1000, 3'd0, 3'd2, 6'd0));
      check("lw_res", result, 32'd3);
      tick();
      check("lw_rt", dut.regs.registers[2], 32'd3);
      apply(i_op(4'b1001, 3'd0, 3'd7, 6'b100011));
      check("sw_wrap_res", result, 32'd3);
      tick();
      check("sw_wrap_mem", dut.data_mem.memory[3], 32'd1);
      apply(i_op(4'b1000, 3'd4, 3'd0, 6'b111111));
      check("lw_base_res", result, 32'd1);

      apply(16'b0101_000_001_000011);
      check("nop5_res", result, 32'd0);
      tick();
      check("nop5_reg", dut.regs.registers[1], 32'd1);
      apply(16'b1010_000_110_000000);
      check("nopa_res", result, 32'd0);
      tick();
      check("nopa_mem", dut.data_mem.memory[0], 32'd3);

      apply(r_op(3'd2, 3'd4, 3'd0, 3'b001));
      check("r0_add_res", result, 32'd7);
      tick();
      check("r0_store", dut.regs.registers[0], 32'd0);
      apply(r_op(3'd0, 3'd0, 3'd0, 3'b101));
      check("r0_read", result, 32'd0);

      apply(r_op(3'd4, 3'd4, 3'd4, 3'b001));
      check("self_add1_res", result, 32'd8);
      tick();
      check("self_add1_rd", dut.regs.registers[4], 32'd8);
      apply(r_op(3'd4, 3'd4, 3'd4, 3'b001));
      check("self_add2_res", result, 32'd16);
      tick();
      check("self_add2_rd", dut.regs.registers[4], 32'd16);
      apply(i_op(4'b0001, 3'd4, 3'd5, 6'b010001));
      check("addi33_res", result, 32'd33);
      tick();
      apply(r_op(3'd6, 3'd5, 3'd0, 3'b111));
      check("sll_trunc", result, 32'd30);

      reset = 1'b1;
      apply(i_op(4'b1001, 3'd0, 3'd6, 6'd3));
      check("reset_ungated_res", result, 32'd3);
      tick();
      reset = 1'b0;
      for (int k = 0; k < 8; k++) check($sformatf("midreset_reg%0d", k), dut.regs.registers[k], 32'd0);
      check("midreset_mem3", dut.data_mem.memory[3], 32'd1);
      check("midreset_mem0", dut.data_mem.memory[0], 32'd3);
      apply(i_op(4'b1000, 3'd0, 3'd0, 6'd3));
      check("post_reset_lw", result, 32'd1);
      apply(i_op(4'b0001, 3'd0, 3'd1, 6'd5));
      check("post_reset_addi_res", result, 32'd5);
      tick();
      check("post_reset_addi_rt", dut.regs.registers[1], 32'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
